// File: rtl/lr35902_brom_loader.sv
// -----------------------------------------------------------------------------
// lr35902_brom_loader
//
// Receives a boot image over a valid/ready byte stream and writes it into a
// 256-byte boot RAM. The CPU is held in reset until a complete frame has been
// received and its checksum verified.
//
// Frame: SYNC_BYTE, 256 image bytes (addresses 0..255 in order), 1 checksum
// byte. The image is good when (sum of image bytes + checksum) mod 256 == 0.
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   start    in   restart request, honoured only in DONE or ERROR
//   s_data   in   [7:0] stream byte
//   s_valid  in   stream byte valid
//   s_ready  out  loader accepts a byte this cycle (SYNC, DATA, CSUM)
//   wr_adr   out  [7:0] boot RAM write address
//   wr_data  out  [7:0] boot RAM write data
//   wr_en    out  boot RAM write strobe, one cycle per image byte
//   hold     out  CPU reset hold, released only in DONE
//   done     out  image loaded and checksum good
//   err      out  checksum mismatch or inter-byte timeout
// -----------------------------------------------------------------------------
module lr35902_brom_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [15:0] TIMEOUT   = 16'd65535
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] wr_adr,
    output logic [7:0] wr_data,
    output logic       wr_en,
    output logic       hold,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  sum_q, sum_d;
    logic [15:0] tmo_q, tmo_d;
    logic        wr_en_q, wr_en_d;
    logic [7:0]  wr_adr_q, wr_adr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        accept;

    // Ready is a pure decode of the state register, so it never depends on
    // s_valid and cannot form a combinational loop with the source.
    assign s_ready = (state_q == ST_SYNC) || (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign accept  = s_valid && s_ready;

    always_comb begin
        // NOTE: every signal written here gets a default first so that no path
        // through the case statement leaves one unassigned and infers a latch.
        state_d   = state_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        tmo_d     = tmo_q;
        wr_en_d   = 1'b0;
        wr_adr_d  = wr_adr_q;
        wr_data_d = wr_data_q;

        unique case (state_q)
            ST_SYNC: begin
                tmo_d = '0;
                if (accept && (s_data == SYNC_BYTE)) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end

            ST_DATA: begin
                // Acceptance is tested before expiry so a byte arriving on the
                // expiry cycle still counts.
                if (accept) begin
                    tmo_d     = '0;
                    wr_en_d   = 1'b1;
                    wr_adr_d  = idx_q;
                    wr_data_d = s_data;
                    sum_d     = 8'(sum_q + s_data);
                    idx_d     = 8'(idx_q + 8'd1);
                    if (idx_q == 8'hFF) begin
                        state_d = ST_CSUM;
                    end
                end else if (tmo_q == TIMEOUT) begin
                    state_d = ST_ERROR;
                    tmo_d   = '0;
                end else begin
                    tmo_d = 16'(tmo_q + 16'd1);
                end
            end

            ST_CSUM: begin
                // start is not looked at here: the checksum result always wins.
                if (accept) begin
                    tmo_d   = '0;
                    state_d = (8'(sum_q + s_data) == 8'h00) ? ST_DONE : ST_ERROR;
                end else if (tmo_q == TIMEOUT) begin
                    state_d = ST_ERROR;
                    tmo_d   = '0;
                end else begin
                    tmo_d = 16'(tmo_q + 16'd1);
                end
            end

            ST_DONE, ST_ERROR: begin
                tmo_d = '0;
                if (start) begin
                    state_d = ST_SYNC;
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end

            default: begin
                state_d = ST_SYNC;
                idx_d   = '0;
                sum_d   = '0;
                tmo_d   = '0;
            end
        endcase

        // Status flags are registered copies of the next state, so they change
        // on the same edge as the state itself.
        hold_d = (state_d != ST_DONE);
        done_d = (state_d == ST_DONE);
        err_d  = (state_d == ST_ERROR);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_SYNC;
            idx_q     <= '0;
            sum_q     <= '0;
            tmo_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_adr_q  <= '0;
            wr_data_q <= '0;
            hold_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            tmo_q     <= tmo_d;
            wr_en_q   <= wr_en_d;
            wr_adr_q  <= wr_adr_d;
            wr_data_q <= wr_data_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_adr  = wr_adr_q;
    assign wr_data = wr_data_q;
    assign hold    = hold_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_lr35902_brom_loader.sv
// -----------------------------------------------------------------------------
// tb_lr35902_brom_loader
//
// Directed bench for lr35902_brom_loader, built with TIMEOUT=16 so that the
// inter-byte timeout can be exercised in a short run. Image byte i always
// carries value i, so the sum of the image is 0x80 and the good checksum is
// 0x80. A monitor counts every write strobe and flags any write whose address
// is out of sequence or whose data differs from its address.
// -----------------------------------------------------------------------------
module tb_lr35902_brom_loader;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [15:0] TIMEOUT   = 16'd16;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] wr_adr;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       hold;
    logic       done;
    logic       err;

    int n_tests;
    int n_fail;

    // Write monitor bookkeeping; only the monitor writes wr_total/bad_total.
    int wr_total;
    int bad_total;
    int frame_base;
    int bad_base;

    lr35902_brom_loader #(
        .SYNC_BYTE(SYNC_BYTE),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .s_data (s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .wr_adr (wr_adr),
        .wr_data(wr_data),
        .wr_en  (wr_en),
        .hold   (hold),
        .done   (done),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sampled on the falling edge, half a cycle after outputs update.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if ((wr_adr !== 8'(wr_total - frame_base)) || (wr_data !== wr_adr)) begin
                bad_total = bad_total + 1;
            end
            wr_total = wr_total + 1;
        end
    end

    // Presents one byte for one cycle; called and returns on a falling edge.
    task automatic send(input logic [7:0] b, input logic with_start);
        s_data  = b;
        s_valid = 1'b1;
        start   = with_start;
        @(negedge clk);
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic begin_frame_log();
        frame_base = wr_total;
        bad_base   = bad_total;
    endtask

    // Full frame: junk byte, sync, 256 image bytes, checksum.
    //   gaps      : insert random 0..3 idle cycles before each image byte
    //   gap_at    : image index preceded by exactly TIMEOUT idle cycles (-1 none)
    //   start_dat : image index sent together with a start pulse (-1 none)
    //   start_cs  : pulse start together with the checksum byte
    task automatic send_frame(input logic [7:0] csum, input bit gaps, input int gap_at,
                              input int start_dat, input bit start_cs);
        begin_frame_log();
        send(8'h00, 1'b0);
        send(SYNC_BYTE, 1'b0);
        for (int i = 0; i < 256; i++) begin
            if (gaps) idle(int'($urandom_range(0, 3)));
            if (i == gap_at) idle(int'(TIMEOUT));
            send(8'(i), (i == start_dat));
        end
        send(csum, start_cs);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int exp_count);
        check({tag, "_nwrites"}, 32'(wr_total - frame_base), 32'(exp_count));
        check({tag, "_badwrites"}, 32'(bad_total - bad_base), 32'd0);
    endtask

    initial begin
        int n_idle;

        n_tests    = 0;
        n_fail     = 0;
        wr_total   = 0;
        bad_total  = 0;
        frame_base = 0;
        bad_base   = 0;
        reset_n    = 1'b0;
        start      = 1'b0;
        s_data     = 8'h00;
        s_valid    = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_wr_en",   32'(wr_en),   32'd0);
        check("rst_wr_adr",  32'(wr_adr),  32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_hold",    32'(hold),    32'd1);
        check("rst_done",    32'(done),    32'd0);
        check("rst_err",     32'(err),     32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // ---- good frame, back-to-back bytes ----
        send_frame(8'h80, 1'b0, -1, -1, 1'b0);
        idle(2);
        check_writes("good", 256);
        check("good_done",    32'(done),    32'd1);
        check("good_hold",    32'(hold),    32'd0);
        check("good_err",     32'(err),     32'd0);
        check("good_s_ready", 32'(s_ready), 32'd0);
        check("good_wr_en",   32'(wr_en),   32'd0);
        check("good_wr_adr_hold", 32'(wr_adr), 32'hFF);

        // start from DONE -> SYNC
        pulse_start();
        check("restart1_done",    32'(done),    32'd0);
        check("restart1_hold",    32'(hold),    32'd1);
        check("restart1_s_ready", 32'(s_ready), 32'd1);

        // ---- bad checksum ----
        send_frame(8'h81, 1'b0, -1, -1, 1'b0);
        idle(2);
        check_writes("badcs", 256);
        check("badcs_err",     32'(err),     32'd1);
        check("badcs_done",    32'(done),    32'd0);
        check("badcs_hold",    32'(hold),    32'd1);
        check("badcs_s_ready", 32'(s_ready), 32'd0);
        pulse_start();
        check("restart2_err",     32'(err),     32'd0);
        check("restart2_s_ready", 32'(s_ready), 32'd1);
        check("restart2_hold",    32'(hold),    32'd1);

        // ---- random valid gaps, all shorter than TIMEOUT ----
        send_frame(8'h80, 1'b1, -1, -1, 1'b0);
        idle(2);
        check_writes("gaps", 256);
        check("gaps_done", 32'(done), 32'd1);
        check("gaps_err",  32'(err),  32'd0);
        pulse_start();

        // ---- timeout after image byte 10 ----
        begin_frame_log();
        send(SYNC_BYTE, 1'b0);
        for (int i = 0; i <= 10; i++) send(8'(i), 1'b0);
        n_idle = 0;
        while ((err !== 1'b1) && (n_idle < 40)) begin
            @(negedge clk);
            n_idle++;
        end
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_latency_in_range", 32'((n_idle >= 16) && (n_idle <= 18)), 32'd1);
        idle(4);
        check_writes("tmo", 11);
        check("tmo_last_adr", 32'(wr_adr), 32'd10);
        check("tmo_hold", 32'(hold), 32'd1);
        pulse_start();

        // ---- reset mid-frame after byte 100 ----
        begin_frame_log();
        send(SYNC_BYTE, 1'b0);
        for (int i = 0; i <= 100; i++) send(8'(i), 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_wr_en",   32'(wr_en),   32'd0);
        check("midrst_wr_adr",  32'(wr_adr),  32'd0);
        check("midrst_wr_data", 32'(wr_data), 32'd0);
        check("midrst_hold",    32'(hold),    32'd1);
        check("midrst_done",    32'(done),    32'd0);
        check("midrst_err",     32'(err),     32'd0);
        check("midrst_s_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        // no start pulse needed after reset
        send_frame(8'h80, 1'b0, -1, -1, 1'b0);
        idle(2);
        check_writes("postrst", 256);
        check("postrst_done", 32'(done), 32'd1);
        pulse_start();

        // ---- start during DATA and with the checksum byte; one gap of exactly
        //      TIMEOUT idle cycles, where acceptance must beat expiry ----
        send_frame(8'h80, 1'b0, 128, 50, 1'b1);
        idle(2);
        check_writes("startign", 256);
        check("startign_done", 32'(done), 32'd1);
        check("startign_err",  32'(err),  32'd0);
        check("startign_hold", 32'(hold), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule
